sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Parametrised single-clock FIFO for blocks that share one clock domain (e.g. the register file to TX path).
- Generalises the pointer/flag scheme of the dual-clock FIFO: depth set by address width, occupancy count, programmable almost-full/almost-empty thresholds, registered read with a valid strobe.
- No synchronisers; binary pointers with one extra wrap bit.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- ADDR_WIDTH, 3, address bits; FIFO_DEPTH = 2**ADDR_WIDTH.
- AF_THRESH, 6, o_ALMOST_FULL asserts when count >= AF_THRESH. Legal range 1..FIFO_DEPTH.
- AE_THRESH, 1, o_ALMOST_EMPTY asserts when count <= AE_THRESH. Legal range 0..FIFO_DEPTH-1.

Ports:
- i_CLK  input  1  clock, rising edge.
- i_RST  input  1  asynchronous, active-low reset.
- i_W_INC  input  1  write request.
- i_WR_DATA  input  DATA_WIDTH  write data.
- i_R_INC  input  1  read request.
- o_RD_DATA  output  DATA_WIDTH  registered read data.
- o_RD_VALID  output  1  one-cycle strobe: o_RD_DATA updated this cycle.
- o_FULL  output  1  count == FIFO_DEPTH.
- o_EMPTY  output  1  count == 0.
- o_ALMOST_FULL  output  1  count >= AF_THRESH.
- o_ALMOST_EMPTY  output  1  count <= AE_THRESH.
- o_COUNT  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- One clock (i_CLK). Reset is asynchronous and active-low (i_RST).
- Reset values:
  - wr_ptr = rd_ptr = 0.
  - o_RD_DATA = 0, o_RD_VALID = 0, o_COUNT = 0.
  - o_EMPTY = 1, o_FULL = 0, o_ALMOST_EMPTY = 1.
  - o_ALMOST_FULL = 0 (AF_THRESH >= 1).
  - Memory array is not reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits, binary. Address = low ADDR_WIDTH bits.
  - Pointers wrap naturally modulo 2**(ADDR_WIDTH+1).
- Count: o_COUNT = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
  - o_FULL when the MSBs differ and the addresses are equal.
  - o_EMPTY when the pointers are equal.
- Write accept: wr_acc = i_W_INC && !o_FULL.
  - Writes mem[wr_addr] <= i_WR_DATA and increments wr_ptr on that edge.
  - A write while full is dropped with no state change.
- Read accept: rd_acc = i_R_INC && !o_EMPTY.
  - Increments rd_ptr.
  - On the same edge, o_RD_DATA <= mem[rd_addr] (the old address) and o_RD_VALID <= 1.
  - Read latency is 1 cycle from the accepting edge.
  - A read while empty is ignored and o_RD_VALID <= 0.
  - o_RD_DATA holds its value when there is no accepted read.
- Simultaneous read and write:
  - Both are accepted when the flag conditions allow; count is unchanged.
  - When full: only the read is accepted, and the write is dropped.
  - When empty: only the write is accepted. No write-through; the word becomes readable the next cycle.
- Flag timing: all flags and o_COUNT are combinational functions of the registered pointers only. They update the cycle after the accepting edge, never from the current inputs.
- Reset mid-operation: the FIFO empties immediately. Stale memory contents are never visible, because o_EMPTY blocks reads.

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- With the macro, three extra ports are added:
  - i_ERR_CLR  input  1.
  - o_OVERFLOW  output  1: sticky, set on i_W_INC && o_FULL.
  - o_UNDERFLOW  output  1: sticky, set on i_R_INC && o_EMPTY.
- Error flag rules:
  - Both flags are cleared by i_ERR_CLR.
  - Set has priority over clear in the same cycle.
  - Both reset to 0.
- Without the macro: these ports and registers are absent; dropped requests are silent.

Decomposition:
- Package sync_fifo_pkg:
  - Default DATA_WIDTH and ADDR_WIDTH constants.
  - A function computing FIFO_DEPTH from ADDR_WIDTH.
  - Threshold legality check constants used by elaboration-time asserts.
- Sub-module sync_fifo_mem:
  - Dual-port register array, FIFO_DEPTH x DATA_WIDTH.
  - Synchronous write with enable; registered read with enable.
  - Owns o_RD_DATA.
- Top-level sync_fifo holds the pointers, count, flags, valid strobe and optional error logic.

Test Plan (DATA_WIDTH=8, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=1):
- Reset then idle: o_EMPTY=1, o_ALMOST_EMPTY=1, o_FULL=0, o_COUNT=0, o_RD_VALID=0, o_RD_DATA=0x00.
- Write 0x10..0x17 on 8 consecutive cycles:
  - o_ALMOST_EMPTY drops after the 2nd write.
  - o_ALMOST_FULL rises after the 6th write.
  - o_FULL=1 and o_COUNT=8 after the 8th write.
  - A 9th write of 0xFF is dropped; o_COUNT stays 8.
- From full, read 8 times: o_RD_DATA = 0x10..0x17 in order, each one cycle after its accepting edge with o_RD_VALID=1; then o_EMPTY=1.
- Continuous write+read for 20 cycles at count=3: o_COUNT stays 3, pointers wrap past 15 and data order is preserved. Then, from full, assert both: only the read is accepted and o_COUNT=7.
- Read while empty: o_RD_VALID=0 and o_RD_DATA unchanged. With SYNC_FIFO_ERR_FLAGS_EN, o_UNDERFLOW=1 until i_ERR_CLR.
- Assert i_RST low mid-burst at count=5: o_COUNT=0 and o_EMPTY=1 asynchronously. After release, the first write/read returns the newly written word.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Used by sync_fifo and sync_fifo_mem (optional macro: SYNC_FIFO_ERR_FLAGS_EN).
package sync_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 3;

    // Legal threshold bounds; the upper AF bound and AE bound follow the depth.
    localparam int AF_THRESH_MIN = 1;
    localparam int AE_THRESH_MIN = 0;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic bit af_thresh_ok(input int thresh, input int addr_width);
        return (thresh >= AF_THRESH_MIN) && (thresh <= fifo_depth(addr_width));
    endfunction

    function automatic bit ae_thresh_ok(input int thresh, input int addr_width);
        return (thresh >= AE_THRESH_MIN) && (thresh <= fifo_depth(addr_width) - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port register array for sync_fifo: synchronous write, registered read.
// The array itself is not reset; only the read data register is.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Holds the last word read when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: binary pointers with a wrap bit, occupancy count,
// almost-full/almost-empty flags and a registered read with a valid strobe.
// Optional sticky overflow/underflow flags under `SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_W_INC,
    input  logic [DATA_WIDTH-1:0] i_WR_DATA,
    input  logic                  i_R_INC,
    output logic [DATA_WIDTH-1:0] o_RD_DATA,
    output logic                  o_RD_VALID,
    output logic                  o_FULL,
    output logic                  o_EMPTY,
    output logic                  o_ALMOST_FULL,
    output logic                  o_ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   o_COUNT
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                  i_ERR_CLR,
    output logic                  o_OVERFLOW,
    output logic                  o_UNDERFLOW
`endif
);

    if (!af_thresh_ok(AF_THRESH, ADDR_WIDTH)) begin : g_af_illegal
        $error("sync_fifo: AF_THRESH outside 1..FIFO_DEPTH");
    end
    if (!ae_thresh_ok(AE_THRESH, ADDR_WIDTH)) begin : g_ae_illegal
        $error("sync_fifo: AE_THRESH outside 0..FIFO_DEPTH-1");
    end

    localparam logic [ADDR_WIDTH:0] AF_LVL  = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_LVL  = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_valid;

    assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // Flags depend only on registered pointers, never on this cycle's requests.
    assign o_COUNT        = wr_ptr - rd_ptr;
    assign o_EMPTY        = (wr_ptr == rd_ptr);
    assign o_FULL         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_addr == rd_addr);
    assign o_ALMOST_FULL  = (o_COUNT >= AF_LVL);
    assign o_ALMOST_EMPTY = (o_COUNT <= AE_LVL);

    // Request/accept: a write is taken when not full, a read when not empty;
    // rejected requests are dropped, and accepted read data appears one cycle
    // later qualified by o_RD_VALID.
    assign wr_acc = i_W_INC && !o_FULL;
    assign rd_acc = i_R_INC && !o_EMPTY;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            rd_valid <= rd_acc;
        end
    end

    assign o_RD_VALID = rd_valid;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (i_CLK),
        .rst_n   (i_RST),
        .wr_en   (wr_acc),
        .wr_addr (wr_addr),
        .wr_data (i_WR_DATA),
        .rd_en   (rd_acc),
        .rd_addr (rd_addr),
        .rd_data (o_RD_DATA)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;

    // Set wins over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (i_W_INC && o_FULL) begin
                overflow <= 1'b1;
            end else if (i_ERR_CLR) begin
                overflow <= 1'b0;
            end
            if (i_R_INC && o_EMPTY) begin
                underflow <= 1'b1;
            end else if (i_ERR_CLR) begin
                underflow <= 1'b0;
            end
        end
    end

    assign o_OVERFLOW  = overflow;
    assign o_UNDERFLOW = underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=8, ADDR_WIDTH=3,
// AF_THRESH=6, AE_THRESH=1); define SYNC_FIFO_ERR_FLAGS_EN to cover error flags.
module tb_sync_fifo;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic       i_CLK;
    logic       i_RST;
    logic       i_W_INC;
    logic [7:0] i_WR_DATA;
    logic       i_R_INC;
    logic [7:0] o_RD_DATA;
    logic       o_RD_VALID;
    logic       o_FULL;
    logic       o_EMPTY;
    logic       o_ALMOST_FULL;
    logic       o_ALMOST_EMPTY;
    logic [3:0] o_COUNT;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       i_ERR_CLR;
    logic       o_OVERFLOW;
    logic       o_UNDERFLOW;
`endif

    sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .i_CLK          (i_CLK),
        .i_RST          (i_RST),
        .i_W_INC        (i_W_INC),
        .i_WR_DATA      (i_WR_DATA),
        .i_R_INC        (i_R_INC),
        .o_RD_DATA      (o_RD_DATA),
        .o_RD_VALID     (o_RD_VALID),
        .o_FULL         (o_FULL),
        .o_EMPTY        (o_EMPTY),
        .o_ALMOST_FULL  (o_ALMOST_FULL),
        .o_ALMOST_EMPTY (o_ALMOST_EMPTY),
        .o_COUNT        (o_COUNT)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .i_ERR_CLR      (i_ERR_CLR),
        .o_OVERFLOW     (o_OVERFLOW),
        .o_UNDERFLOW    (o_UNDERFLOW)
`endif
    );

    // Clock / reset
    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // Scoreboard and reference state
    logic [7:0] exp_q[$];
    int         mcount;
    logic [7:0] last_rd;
    logic       exp_valid;
    logic       m_ovf;
    logic       m_unf;
    int         checks;
    int         failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".count"}, 32'(o_COUNT), 32'(mcount));
        check({tag, ".empty"}, 32'(o_EMPTY), 32'(mcount == 0));
        check({tag, ".full"}, 32'(o_FULL), 32'(mcount == DEPTH));
        check({tag, ".almost_full"}, 32'(o_ALMOST_FULL), 32'(mcount >= AF));
        check({tag, ".almost_empty"}, 32'(o_ALMOST_EMPTY), 32'(mcount <= AE));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check({tag, ".overflow"}, 32'(o_OVERFLOW), 32'(m_ovf));
        check({tag, ".underflow"}, 32'(o_UNDERFLOW), 32'(m_unf));
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        mcount    = 0;
        last_rd   = 8'h00;
        exp_valid = 1'b0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
    endtask

    // Driver: called at a falling edge, applies one cycle of requests,
    // returns at the next falling edge after checking the DUT against the model.
    task automatic cycle(input string tag, input logic w, input logic [7:0] wd,
                         input logic r, input logic clr);
        logic wr_ok;
        logic rd_ok;
        i_W_INC   = w;
        i_WR_DATA = wd;
        i_R_INC   = r;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        i_ERR_CLR = clr;
`endif
        wr_ok = w && (mcount != DEPTH);
        rd_ok = r && (mcount != 0);
        if (w && mcount == DEPTH) m_ovf = 1'b1;
        else if (clr)             m_ovf = 1'b0;
        if (r && mcount == 0)     m_unf = 1'b1;
        else if (clr)             m_unf = 1'b0;
        if (rd_ok) last_rd = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(wd);
        mcount    = mcount + int'(wr_ok) - int'(rd_ok);
        exp_valid = rd_ok;
        @(posedge i_CLK);
        @(negedge i_CLK);
        i_W_INC   = 1'b0;
        i_WR_DATA = 8'h00;
        i_R_INC   = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        i_ERR_CLR = 1'b0;
`endif
        check({tag, ".rd_valid"}, 32'(o_RD_VALID), 32'(exp_valid));
        check({tag, ".rd_data"}, 32'(o_RD_DATA), 32'(last_rd));
        check_flags(tag);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        i_RST     = 1'b0;
        i_W_INC   = 1'b0;
        i_WR_DATA = 8'h00;
        i_R_INC   = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        i_ERR_CLR = 1'b0;
`endif
        model_reset();

        // Reset then idle
        repeat (2) @(negedge i_CLK);
        i_RST = 1'b1;
        check("reset.rd_valid", 32'(o_RD_VALID), 32'd0);
        check("reset.rd_data", 32'(o_RD_DATA), 32'h00);
        check_flags("reset");
        cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Fill 0x10..0x17, then a dropped write while full
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        end
        cycle("write_full", 1'b1, 8'hFF, 1'b0, 1'b0);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // Streaming at count=3 with pointer wrap
        for (int i = 0; i < 3; i++) begin
            cycle("prefill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            cycle("stream", 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        end

        // From full, read and write together: only the read is taken
        for (int i = 0; i < 5; i++) begin
            cycle("refill", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        end
        cycle("full_rw", 1'b1, 8'hEE, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // From empty, read and write together: only the write is taken
        cycle("empty_rw", 1'b1, 8'h5A, 1'b1, 1'b0);
        cycle("empty_rw_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        // Read while empty, then error clear
        cycle("read_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("read_empty_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("err_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-burst at count=5
        for (int i = 0; i < 5; i++) begin
            cycle("burst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        end
        #2;
        i_RST = 1'b0;
        model_reset();
        #1;
        check("async_rst.count", 32'(o_COUNT), 32'd0);
        check("async_rst.empty", 32'(o_EMPTY), 32'd1);
        check("async_rst.rd_valid", 32'(o_RD_VALID), 32'd0);
        @(negedge i_CLK);
        i_RST = 1'b1;
        check_flags("post_rst");
        cycle("post_rst_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
        cycle("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
